// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM; sequences the shared datapath (PC, memory, regfile, ALU, muxes) through fetch/decode/execute/mem/writeback. Inputs: clk, reset, opcode, funct, mem_ready. Outputs: PC/memory/IR/regfile enables, mux selects, alu_op, sticky illegal flag, debug state.
module multicycle_control #(
  parameter logic [2:0] ALU_ADD = 3'd0,
  parameter logic [2:0] ALU_SUB = 3'd1,
  parameter logic [2:0] ALU_XOR = 3'd2,
  parameter logic [2:0] ALU_SLT = 3'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       branch_eq,
  output logic       branch_ne,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_re,
  output logic       mem_we,
  output logic       ir_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_we,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11,
    JAL    = 4'd12,
    JR     = 4'd13
  } state_t;
  state_t cur, nxt;
  logic r_ok, bad;
  assign state = cur;
  assign r_ok = funct inside {6'b100000, 6'b100010, 6'b100110, 6'b101010};
  // Every legal decode target is a non-FETCH state, so DECODE->FETCH means unsupported.
  assign bad = (cur == DECODE) && (nxt == FETCH);
  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= FETCH;
      illegal <= 1'b0;
    end else begin
      cur     <= nxt;
      illegal <= illegal | bad;
    end
  end
  always_comb begin
    nxt        = FETCH;
    pc_we      = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    pc_src     = 2'd0;
    iord       = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    reg_we     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = ALU_ADD;
    case (cur)
      FETCH: begin
        nxt       = mem_ready ? DECODE : FETCH;
        mem_re    = 1'b1;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        alu_src_b = 2'd1;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          6'b100011, 6'b101011: nxt = MEMADR;
          6'b000000:            nxt = (funct == 6'b001000) ? JR : r_ok ? REXEC : FETCH;
          6'b000100, 6'b000101: nxt = BRANCH;
          6'b001000, 6'b001110: nxt = IEXEC;
          6'b000010:            nxt = JUMP;
          6'b000011:            nxt = JAL;
          default:              nxt = FETCH;
        endcase
      end
      MEMADR: begin
        nxt       = (opcode == 6'b100011) ? MEMRD : MEMWR;
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      MEMRD: begin
        nxt    = mem_ready ? MEMWB : MEMRD;
        mem_re = 1'b1;
        iord   = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 2'd1;
        reg_we     = 1'b1;
      end
      MEMWR: begin
        nxt    = mem_ready ? FETCH : MEMWR;
        mem_we = 1'b1;
        iord   = 1'b1;
      end
      REXEC: begin
        nxt       = RWB;
        alu_src_a = 1'b1;
        alu_op    = (funct == 6'b100010) ? ALU_SUB :
                    (funct == 6'b100110) ? ALU_XOR :
                    (funct == 6'b101010) ? ALU_SLT : ALU_ADD;
      end
      RWB: begin
        reg_dst = 2'd1;
        reg_we  = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'd1;
        branch_eq = (opcode == 6'b000100);
        branch_ne = (opcode == 6'b000101);
      end
      IEXEC: begin
        nxt       = IWB;
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = (opcode == 6'b001110) ? ALU_XOR : ALU_ADD;
      end
      IWB: reg_we = 1'b1;
      JUMP: begin
        pc_src = 2'd2;
        pc_we  = 1'b1;
      end
      JAL: begin
        pc_src     = 2'd2;
        pc_we      = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        reg_we     = 1'b1;
      end
      JR: begin
        pc_src = 2'd3;
        pc_we  = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end
endmodule
